tex_addr_gen: RTL and testbench

Texel address generator sitting directly downstream of the texture-coordinate-to-integer stage in the texture cache path. It accepts integer texel coordinates (u, v) with texture dimensions and a base address, applies the wrap mode, and emits byte addresses to the texture fetch port over a valid/ready handshake. With bilinear enabled it sequences the 2x2 texel footprint as four fetches; otherwise it issues one fetch per request.

---
 rtl/tex_addr_gen_if.sv | 33 +++
 rtl/tex_addr_gen.sv | 180 ++++++++++++++++++
 tb/tb_tex_addr_gen.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tex_addr_gen_if.sv
// Request/fetch handshake bundle for tex_addr_gen.
// slave: block side (takes requests, drives fetches); master: the surrounding pipeline.
interface tex_addr_gen_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [10:0]       u_i;
    logic [10:0]       v_i;
    logic [10:0]       tx_width_i;
    logic [10:0]       tx_height_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              wrap_i;
    logic              fetch_valid_o;
    logic              fetch_ready_i;
    logic [ADDR_W-1:0] fetch_addr_o;
    logic [1:0]        fetch_idx_o;
    logic              fetch_last_o;

    modport slave (
        input  req_valid_i, u_i, v_i, tx_width_i, tx_height_i,
        input  base_addr_i, wrap_i, fetch_ready_i,
        output req_ready_o, fetch_valid_o, fetch_addr_o,
        output fetch_idx_o, fetch_last_o
    );

    modport master (
        output req_valid_i, u_i, v_i, tx_width_i, tx_height_i,
        output base_addr_i, wrap_i, fetch_ready_i,
        input  req_ready_o, fetch_valid_o, fetch_addr_o,
        input  fetch_idx_o, fetch_last_o
    );
endinterface

// File: rtl/tex_addr_gen.sv
// Texel address generator: sanitises (u,v), applies wrap, emits texel byte addresses.
// Ports: core_clock_i, core_reset_n_i (async low), bus (tex_addr_gen_if.slave).
// Macro TEX_BILINEAR_EN: issue the 2x2 footprint (4 fetches) instead of one fetch.
module tex_addr_gen #(
    parameter int ADDR_W           = 32,
    parameter int TEXEL_BYTES_LOG2 = 2
) (
    input  logic          core_clock_i,
    input  logic          core_reset_n_i,
    tex_addr_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              w_req_ready;
    logic              w_fetch_valid;
    logic              w_accept;
    logic              w_fire;
    logic              w_last;
    logic              w_issue;

    logic [10:0]       w_w;
    logic [10:0]       w_h;
    logic [10:0]       w_u;
    logic [10:0]       w_v;

    logic [ADDR_W-1:0] r_base;
    logic [10:0]       r_u;
    logic [10:0]       r_v;
    logic [10:0]       r_w;
    logic [21:0]       r_row0;

    logic [10:0]       w_col;
    logic [21:0]       w_row;
    logic [22:0]       w_sum;
    logic [ADDR_W-1:0] w_addr;

`ifdef TEX_BILINEAR_EN
    logic [11:0]       w_u_inc;
    logic [11:0]       w_v_inc;
    logic [10:0]       w_u1;
    logic [10:0]       w_v1;
    logic [10:0]       r_u1;
    logic [10:0]       r_v1;
    logic [21:0]       r_row1;
    logic [1:0]        r_idx;
`endif

    // Zero dimensions behave as 1; out-of-range coords clamp to the edge
    // regardless of wrap mode.
    always_comb begin
        w_w = (bus.tx_width_i == 11'd0) ? 11'd1 : bus.tx_width_i;
        w_h = (bus.tx_height_i == 11'd0) ? 11'd1 : bus.tx_height_i;
        w_u = (bus.u_i >= w_w) ? w_w - 11'd1 : bus.u_i;
        w_v = (bus.v_i >= w_h) ? w_h - 11'd1 : bus.v_i;
    end

`ifdef TEX_BILINEAR_EN
    // Neighbour only ever overshoots by one, so a single compare suffices.
    always_comb begin
        w_u_inc = {1'b0, w_u} + 12'd1;
        w_v_inc = {1'b0, w_v} + 12'd1;
        w_u1    = w_u_inc[10:0];
        w_v1    = w_v_inc[10:0];
        if (w_u_inc == {1'b0, w_w}) begin
            w_u1 = bus.wrap_i ? 11'd0 : w_w - 11'd1;
        end
        if (w_v_inc == {1'b0, w_h}) begin
            w_v1 = bus.wrap_i ? 11'd0 : w_h - 11'd1;
        end
    end
`endif

    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_req_ready   = 1'b0;
        w_fetch_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid_i) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                w_next = ISSUE;
            end
            ISSUE: begin
                w_fetch_valid = 1'b1;
                if (bus.fetch_ready_i && w_last) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_issue  = (r_state == ISSUE);
    assign w_accept = bus.req_valid_i && w_req_ready;
    assign w_fire   = w_fetch_valid && bus.fetch_ready_i;

    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            r_base <= '0;
            r_u    <= '0;
            r_v    <= '0;
            r_w    <= '0;
            r_row0 <= '0;
        end else begin
            if (w_accept) begin
                r_base <= bus.base_addr_i;
                r_u    <= w_u;
                r_v    <= w_v;
                r_w    <= w_w;
            end
            if (r_state == CALC) begin
                r_row0 <= {11'd0, r_v} * {11'd0, r_w};
            end
        end
    end

`ifdef TEX_BILINEAR_EN
    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            r_u1   <= '0;
            r_v1   <= '0;
            r_row1 <= '0;
            r_idx  <= '0;
        end else begin
            if (w_accept) begin
                r_u1 <= w_u1;
                r_v1 <= w_v1;
            end
            if (r_state == CALC) begin
                r_row1 <= {11'd0, r_v1} * {11'd0, r_w};
                r_idx  <= 2'd0;
            end else if (w_fire) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // idx bit 0 selects the right column, bit 1 the lower row.
    assign w_col  = r_idx[0] ? r_u1 : r_u;
    assign w_row  = r_idx[1] ? r_row1 : r_row0;
    assign w_last = w_issue && (r_idx == 2'd3);
    assign bus.fetch_idx_o = w_issue ? r_idx : 2'd0;
`else
    assign w_col  = r_u;
    assign w_row  = r_row0;
    assign w_last = w_issue;
    assign bus.fetch_idx_o = 2'd0;
`endif

    assign w_sum  = {1'b0, w_row} + {12'd0, w_col};
    assign w_addr = r_base + (ADDR_W'(w_sum) << TEXEL_BYTES_LOG2);

    assign bus.req_ready_o   = w_req_ready;
    assign bus.fetch_valid_o = w_fetch_valid;
    assign bus.fetch_addr_o  = w_issue ? w_addr : '0;
    assign bus.fetch_last_o  = w_last;

endmodule

// File: tb/tb_tex_addr_gen.sv
// Randomised + directed bench for tex_addr_gen against a behavioural model.
// Works in both point and bilinear (TEX_BILINEAR_EN) builds.
module tb_tex_addr_gen;

`ifdef TEX_BILINEAR_EN
    localparam int NF = 4;
`else
    localparam int NF = 1;
`endif
    localparam int REQ_CYC = 2 + NF;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tex_addr_gen_if #(.ADDR_W(32)) bus ();

    tex_addr_gen #(
        .ADDR_W          (32),
        .TEXEL_BYTES_LOG2(2)
    ) dut (
        .core_clock_i  (clk),
        .core_reset_n_i(rst_n),
        .bus           (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  idx;
        logic        last;
    } fe_t;

    fe_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  rdy_mode = 1;
    int  stall_n  = 0;
    bit  tp_on    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic model of the address of footprint entry k.
    function automatic logic [31:0] model_addr(input int u, input int v,
            input int w, input int h, input logic [31:0] base,
            input bit wrap, input int k);
        int W, H, uc, vc, un, vn, x, y;
        W  = (w == 0) ? 1 : w;
        H  = (h == 0) ? 1 : h;
        uc = (u >= W) ? W - 1 : u;
        vc = (v >= H) ? H - 1 : v;
        un = (uc + 1 == W) ? (wrap ? 0 : W - 1) : uc + 1;
        vn = (vc + 1 == H) ? (wrap ? 0 : H - 1) : vc + 1;
        x  = (k % 2 == 1) ? un : uc;
        y  = (k / 2 == 1) ? vn : vc;
        return base + 32'((y * W + x) * 4);
    endfunction

    // fetch_ready driver: 0 random, 1 always, 2 three-cycle stall, 3 never
    initial begin
        bus.fetch_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.fetch_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (bus.fetch_valid_o && stall_n < 3 &&
                        (NF == 1 || bus.fetch_idx_o == 2'd1)) begin
                        bus.fetch_ready_i = 1'b0;
                        stall_n++;
                    end else begin
                        bus.fetch_ready_i = 1'b1;
                    end
                end
                3: bus.fetch_ready_i = 1'b0;
                default: bus.fetch_ready_i = 1'b1;
            endcase
        end
    end

    // Single compare process
    bit          prev_hold = 0;
    logic [31:0] prev_addr;
    logic [1:0]  prev_idx;
    int          acc_cyc = 0;
    int          last_acc = 0;
    bit          lat_pend = 0;
    bit          have_last = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
            lat_pend  = 0;
            have_last = 0;
        end else begin
            if (bus.req_valid_i && bus.req_ready_o) begin
                for (int k = 0; k < NF; k++) begin
                    fe_t e;
                    e.addr = model_addr(int'(bus.u_i), int'(bus.v_i),
                                        int'(bus.tx_width_i), int'(bus.tx_height_i),
                                        bus.base_addr_i, bus.wrap_i, k);
                    e.idx  = 2'(k);
                    e.last = (k == NF - 1);
                    exp_q.push_back(e);
                end
                if (tp_on && have_last)
                    chk("throughput", 64'(cyc - last_acc), 64'(REQ_CYC));
                last_acc  = cyc;
                have_last = tp_on;
                acc_cyc   = cyc;
                lat_pend  = 1;
            end
            if (prev_hold)
                chk("hold", {bus.fetch_valid_o, bus.fetch_addr_o, bus.fetch_idx_o},
                    {1'b1, prev_addr, prev_idx});
            if (bus.fetch_valid_o) begin
                chk("busy_ready", 64'(bus.req_ready_o), 64'd0);
                if (lat_pend) begin
                    chk("latency", 64'(cyc - acc_cyc), 64'd2);
                    lat_pend = 0;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_fetch: got addr %0h want none",
                             bus.fetch_addr_o);
                end else begin
                    chk("fetch", {bus.fetch_addr_o, bus.fetch_idx_o, bus.fetch_last_o},
                        {exp_q[0].addr, exp_q[0].idx, exp_q[0].last});
                    if (bus.fetch_ready_i) void'(exp_q.pop_front());
                end
            end
            prev_hold = bus.fetch_valid_o && !bus.fetch_ready_i;
            prev_addr = bus.fetch_addr_o;
            prev_idx  = bus.fetch_idx_o;
        end
    end

    task automatic scramble();
        bus.u_i         = 11'($urandom);
        bus.v_i         = 11'($urandom);
        bus.tx_width_i  = 11'($urandom);
        bus.tx_height_i = 11'($urandom);
        bus.base_addr_i = $urandom;
        bus.wrap_i      = 1'($urandom);
    endtask

    // Call #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input int u, input int v, input int w, input int h,
                        input logic [31:0] base, input bit wrap);
        bit a;
        int n;
        bus.u_i         = 11'(u);
        bus.v_i         = 11'(v);
        bus.tx_width_i  = 11'(w);
        bus.tx_height_i = 11'(h);
        bus.base_addr_i = base;
        bus.wrap_i      = wrap;
        bus.req_valid_i = 1'b1;
        n = 0;
        a = 0;
        while (!a && n < 200) begin
            @(negedge clk);
            a = bus.req_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!a) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept want accept");
        end
        bus.req_valid_i = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        bus.req_valid_i = 1'b0;
        scramble();
        #2 rst_n = 1'b0;
        #10;
        chk("rst_valid", 64'(bus.fetch_valid_o), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_addr", 64'(bus.fetch_addr_o), 64'd0);
        chk("rst_idx", 64'(bus.fetch_idx_o), 64'd0);
        chk("rst_last", 64'(bus.fetch_last_o), 64'd0);

        chk("pin_base", 64'(model_addr(5, 3, 64, 32, 32'h1000, 0, 0)), 64'h1314);
        chk("pin_corner", 64'(model_addr(63, 31, 64, 32, 32'h1000, 1, 0)), 64'h2FFC);
        chk("pin_oor_u", 64'(model_addr(70, 3, 64, 32, 32'h1000, 0, 0)), 64'h13FC);
        chk("pin_w0", 64'(model_addr(5, 3, 0, 32, 32'h1000, 0, 0)), 64'h100C);
        chk("pin_b1", 64'(model_addr(5, 3, 64, 32, 32'h1000, 0, 1)), 64'h1318);
        chk("pin_b2", 64'(model_addr(5, 3, 64, 32, 32'h1000, 0, 2)), 64'h1414);
        chk("pin_b3", 64'(model_addr(5, 3, 64, 32, 32'h1000, 0, 3)), 64'h1418);
        chk("pin_clamp3", 64'(model_addr(63, 31, 64, 32, 32'h1000, 0, 3)), 64'h2FFC);
        chk("pin_rep1", 64'(model_addr(63, 31, 64, 32, 32'h1000, 1, 1)), 64'h2F00);
        chk("pin_rep2", 64'(model_addr(63, 31, 64, 32, 32'h1000, 1, 2)), 64'h10FC);
        chk("pin_rep3", 64'(model_addr(63, 31, 64, 32, 32'h1000, 1, 3)), 64'h1000);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rdy_mode = 1;
        send(5, 3, 64, 32, 32'h1000, 0);
        drain();
        send(63, 31, 64, 32, 32'h1000, 0);
        send(63, 31, 64, 32, 32'h1000, 1);
        send(70, 3, 64, 32, 32'h1000, 0);
        send(5, 3, 0, 32, 32'h1000, 0);
        send(2047, 2047, 2047, 2047, 32'hFFFF_FF00, 1);
        drain();

        tp_on = 1;
        send(1, 2, 16, 16, 32'h2000, 0);
        send(15, 15, 16, 16, 32'h2000, 1);
        send(7, 0, 16, 16, 32'h2000, 1);
        drain();
        tp_on = 0;

        rdy_mode = 2;
        stall_n  = 0;
        send(5, 3, 64, 32, 32'h1000, 0);
        drain();
        chk("stall_cycles", 64'(stall_n), 64'd3);
        rdy_mode = 1;

        rdy_mode = 0;
        for (int i = 0; i < 80; i++) begin
            int w, h, u, v;
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 70);
            h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 70);
            u = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 80);
            v = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 80);
            send(u, v, w, h, $urandom, 1'($urandom));
        end
        drain();

        rdy_mode = 1;
        send(5, 3, 64, 32, 32'h1000, 0);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus.fetch_valid_o && bus.fetch_idx_o == 2'((NF == 4) ? 2 : 0)) break;
        end
        chk("mid_issue_seen", 64'(bus.fetch_valid_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus.fetch_valid_o), 64'd0);
        chk("rst_mid_addr", 64'(bus.fetch_addr_o), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 64'(bus.req_ready_o), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("rst_rel_idle", 64'(bus.fetch_valid_o), 64'd0);

        send(10, 4, 64, 32, 32'h4000, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
